// File: rtl/act_pkg.sv
// Shared definitions for the activation unit: mode encoding, segment classes,
// and piecewise-linear breakpoints/offsets expressed as functions of FRAC.
package act_pkg;

  typedef enum logic [1:0] {
    ACT_LRELU   = 2'b00,
    ACT_SIGMOID = 2'b01,
    ACT_TANH    = 2'b10,
    ACT_BYPASS  = 2'b11
  } act_mode_e;

  typedef enum logic [1:0] {
    SEG_LO  = 2'b00,
    SEG_MID = 2'b01,
    SEG_HI  = 2'b10
  } act_seg_e;

  function automatic int q_one(input int frac);
    return 1 << frac;
  endfunction

  function automatic int sig_bp1(input int frac);
    return 1 << frac;
  endfunction

  function automatic int sig_bp2(input int frac);
    return 3 << frac;
  endfunction

  function automatic int tanh_bp1(input int frac);
    return 1 << (frac - 1);
  endfunction

  function automatic int tanh_bp2(input int frac);
    return 3 << (frac - 1);
  endfunction

  function automatic int sig_off0(input int frac);
    return 1 << (frac - 1);
  endfunction

  // 0.625, floored when FRAC is too small to represent it exactly
  function automatic int sig_off1(input int frac);
    return (5 << frac) >> 3;
  endfunction

  function automatic int tanh_off(input int frac);
    return 1 << (frac - 2);
  endfunction

endpackage

// File: rtl/act_lane.sv
// One lane of the activation datapath: stage 1 classifies the input and forms
// the LReLU product, stage 2 evaluates the selected function and saturates.
module act_lane
  import act_pkg::*;
#(
  parameter int W    = 16,
  parameter int FRAC = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [W-1:0] x,
  input  logic [1:0]   mode,
  input  logic [W-1:0] slope,
  output logic [W-1:0] y,
  output logic         sat
);

  localparam int W2 = 2 * W;
  localparam logic [W-1:0] SB1 = W'(sig_bp1(FRAC));
  localparam logic [W-1:0] SB2 = W'(sig_bp2(FRAC));
  localparam logic [W-1:0] TB1 = W'(tanh_bp1(FRAC));
  localparam logic [W-1:0] TB2 = W'(tanh_bp2(FRAC));
  localparam logic signed [W2-1:0] ONEW = W2'(q_one(FRAC));
  localparam logic signed [W2-1:0] SO0W = W2'(sig_off0(FRAC));
  localparam logic signed [W2-1:0] SO1W = W2'(sig_off1(FRAC));
  localparam logic signed [W2-1:0] TOW  = W2'(tanh_off(FRAC));
  localparam logic signed [W2-1:0] MAXV = {{(W+1){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [W2-1:0] MINV = {{(W+1){1'b1}}, {(W-1){1'b0}}};

  function automatic logic [W-1:0] sat_w(input logic signed [W2-1:0] v);
    if (v > MAXV)      return MAXV[W-1:0];
    else if (v < MINV) return MINV[W-1:0];
    else               return v[W-1:0];
  endfunction

  function automatic logic sat_hit(input logic signed [W2-1:0] v);
    return (v > MAXV) || (v < MINV);
  endfunction

  logic signed [W2-1:0] xw_c, sw_c, prod_full, prod_c;
  logic                 x_min;
  logic [W-1:0]         u_c;
  act_seg_e             seg_c;

  assign xw_c      = $signed({{W{x[W-1]}}, x});
  assign sw_c      = $signed({{W{slope[W-1]}}, slope});
  assign prod_full = xw_c * sw_c;
  assign prod_c    = prod_full >>> FRAC;
  assign x_min     = (x == MINV[W-1:0]);
  // |most-negative| is not representable, so it clamps to the positive limit
  assign u_c = x_min ? MAXV[W-1:0] : (x[W-1] ? (~x + {{(W-1){1'b0}}, 1'b1}) : x);

  always_comb begin
    seg_c = SEG_LO;
    case (act_mode_e'(mode))
      ACT_SIGMOID: begin
        if (u_c >= SB2)      seg_c = SEG_HI;
        else if (u_c >= SB1) seg_c = SEG_MID;
      end
      ACT_TANH: begin
        if (u_c >= TB2)      seg_c = SEG_HI;
        else if (u_c >= TB1) seg_c = SEG_MID;
      end
      default: seg_c = SEG_LO;
    endcase
  end

  // stage 1: classify input, capture |x|, sign and LReLU product
  logic [W-1:0]         x_p1, u_p1;
  logic                 neg_p1, pos_p1, abssat_p1;
  act_seg_e             seg_p1;
  act_mode_e            mode_p1;
  logic signed [W2-1:0] prod_p1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      x_p1      <= '0;
      u_p1      <= '0;
      neg_p1    <= 1'b0;
      pos_p1    <= 1'b0;
      abssat_p1 <= 1'b0;
      seg_p1    <= SEG_LO;
      mode_p1   <= ACT_LRELU;
      prod_p1   <= '0;
    end else if (en) begin
      x_p1      <= x;
      u_p1      <= u_c;
      neg_p1    <= x[W-1];
      pos_p1    <= !x[W-1] && (x != '0);
      abssat_p1 <= x_min;
      seg_p1    <= seg_c;
      mode_p1   <= act_mode_e'(mode);
      prod_p1   <= prod_c;
    end
  end

  logic signed [W2-1:0] uw, xw_p1, f_c, r_c;
  logic                 flag_c;

  assign uw    = $signed({{W{1'b0}}, u_p1});
  assign xw_p1 = $signed({{W{x_p1[W-1]}}, x_p1});

  always_comb begin
    f_c    = '0;
    r_c    = xw_p1;
    flag_c = 1'b0;
    case (mode_p1)
      ACT_LRELU: r_c = pos_p1 ? xw_p1 : prod_p1;
      ACT_SIGMOID: begin
        case (seg_p1)
          SEG_LO:  f_c = (uw >>> 2) + SO0W;
          SEG_MID: f_c = (uw >>> 3) + SO1W;
          default: f_c = ONEW;
        endcase
        r_c    = neg_p1 ? (ONEW - f_c) : f_c;
        flag_c = abssat_p1;
      end
      ACT_TANH: begin
        case (seg_p1)
          SEG_LO:  f_c = uw;
          SEG_MID: f_c = (uw >>> 1) + TOW;
          default: f_c = ONEW;
        endcase
        r_c    = neg_p1 ? -f_c : f_c;
        flag_c = abssat_p1;
      end
      default: r_c = xw_p1;
    endcase
  end

  // stage 2: saturated result and saturation flag
  logic [W-1:0] y_p2;
  logic         sat_p2;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      y_p2   <= '0;
      sat_p2 <= 1'b0;
    end else if (en) begin
      y_p2   <= sat_w(r_c);
      sat_p2 <= sat_hit(r_c) || flag_c;
    end
  end

  assign y   = y_p2;
  assign sat = sat_p2;

endmodule

// File: rtl/activation_unit.sv
// Multi-lane activation unit with a shared valid/ready handshake and 2-cycle latency.
// Optional saturation counter ports enabled by defining ACT_SAT_COUNT_EN.
module activation_unit
  import act_pkg::*;
#(
  parameter int W     = 16,
  parameter int FRAC  = 8,
  parameter int LANES = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [LANES*W-1:0]   in_data,
  input  logic [1:0]           in_mode,
  input  logic [W-1:0]         in_slope,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [LANES*W-1:0]   out_data
`ifdef ACT_SAT_COUNT_EN
  ,
  input  logic                 sat_clr,
  output logic [15:0]          sat_cnt
`endif
);

  logic             vld_p1, vld_p2;
  logic             advance;
  logic [LANES-1:0] sat_lane;

  // whole pipeline moves together; a stalled output freezes every stage
  assign advance   = !vld_p2 || out_ready;
  assign in_ready  = rst_n && advance;
  assign out_valid = vld_p2;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
    end else if (advance) begin
      vld_p1 <= in_valid;
      vld_p2 <= vld_p1;
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    act_lane #(
      .W    (W),
      .FRAC (FRAC)
    ) u_lane (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (advance),
      .x     (in_data[g*W +: W]),
      .mode  (in_mode),
      .slope (in_slope),
      .y     (out_data[g*W +: W]),
      .sat   (sat_lane[g])
    );
  end

`ifdef ACT_SAT_COUNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n)
      sat_cnt <= '0;
    else if (sat_clr)
      sat_cnt <= '0;
    else if (vld_p2 && out_ready && (|sat_lane) && (sat_cnt != 16'hFFFF))
      sat_cnt <= sat_cnt + 16'd1;
  end
`else
  logic unused_sat;
  assign unused_sat = ^sat_lane;
`endif

endmodule

// File: tb/tb_activation_unit.sv
// Directed self-checking bench for activation_unit (W=16, FRAC=8, LANES=4).
module tb_activation_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic [1:0]  in_mode = 2'b00;
  logic [15:0] in_slope = 16'd0;
  logic [63:0] in_data = 64'd0;
  wire         in_ready;
  wire         out_valid;
  wire  [63:0] out_data;
`ifdef ACT_SAT_COUNT_EN
  logic        sat_clr = 1'b0;
  wire  [15:0] sat_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  activation_unit #(.W(16), .FRAC(8), .LANES(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_mode   (in_mode),
    .in_slope  (in_slope),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
`ifdef ACT_SAT_COUNT_EN
    ,
    .sat_clr   (sat_clr),
    .sat_cnt   (sat_cnt)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [63:0] d, input logic [1:0] m, input logic [15:0] s);
    in_valid = 1'b1;
    in_data  = d;
    in_mode  = m;
    in_slope = s;
  endtask

  function automatic logic [63:0] pat(input int k);
    return {16'(16'h1000 + k), 16'(16'h8000 + k), 16'(k * 3), 16'(16'hFFF0 - k)};
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0;
    tick(); tick();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid got %b exp 0", out_valid); end
    n_checks++; if (out_data !== 64'd0) begin n_fail++; $display("FAIL rst_out_data got %h exp 0", out_data); end
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_in_ready got %b exp 0", in_ready); end
`ifdef ACT_SAT_COUNT_EN
    n_checks++; if (sat_cnt !== 16'd0) begin n_fail++; $display("FAIL rst_sat_cnt got %0d exp 0", sat_cnt); end
`endif
    rst_n = 1'b1;
    #1;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL post_rst_in_ready got %b exp 1", in_ready); end
    tick();
  endtask

  task automatic test_sigmoid();
    out_ready = 1'b1;
    put({16'd1024, -16'sd512, 16'd512, 16'd0}, 2'b01, 16'd0);
    tick();
    put({16'd768, 16'd767, 16'd256, 16'd255}, 2'b01, 16'd0);
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL sig_latency1 got %b exp 0", out_valid); end
    tick();
    put({16'h8000, -16'sd255, -16'sd768, -16'sd1}, 2'b01, 16'd0);
    n_checks++; if (out_valid !== 1'b1 || out_data !== {16'd256, 16'd32, 16'd224, 16'd128})
      begin n_fail++; $display("FAIL sig_basic got v=%b %h exp v=1 %h", out_valid, out_data, {16'd256, 16'd32, 16'd224, 16'd128}); end
    tick();
    in_valid = 1'b0;
    n_checks++; if (out_valid !== 1'b1 || out_data !== {16'd256, 16'd255, 16'd192, 16'd191})
      begin n_fail++; $display("FAIL sig_bounds got v=%b %h exp v=1 %h", out_valid, out_data, {16'd256, 16'd255, 16'd192, 16'd191}); end
    tick();
    n_checks++; if (out_valid !== 1'b1 || out_data !== {16'd0, 16'd65, 16'd0, 16'd128})
      begin n_fail++; $display("FAIL sig_neg got v=%b %h exp v=1 %h", out_valid, out_data, {16'd0, 16'd65, 16'd0, 16'd128}); end
    tick();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL sig_drain got %b exp 0", out_valid); end
  endtask

  task automatic test_tanh();
    put({16'd512, -16'sd256, 16'd256, 16'd64}, 2'b10, 16'd0);
    tick();
    put({16'd383, 16'd384, 16'd127, 16'd128}, 2'b10, 16'd0);
    tick();
    put({16'h8000, -16'sd383, -16'sd128, -16'sd1}, 2'b10, 16'd0);
    n_checks++; if (out_valid !== 1'b1 || out_data !== {16'd256, -16'sd192, 16'd192, 16'd64})
      begin n_fail++; $display("FAIL tanh_basic got v=%b %h exp v=1 %h", out_valid, out_data, {16'd256, -16'sd192, 16'd192, 16'd64}); end
    tick();
    in_valid = 1'b0;
    n_checks++; if (out_valid !== 1'b1 || out_data !== {16'd255, 16'd256, 16'd127, 16'd128})
      begin n_fail++; $display("FAIL tanh_bounds got v=%b %h exp v=1 %h", out_valid, out_data, {16'd255, 16'd256, 16'd127, 16'd128}); end
    tick();
    n_checks++; if (out_valid !== 1'b1 || out_data !== {-16'sd256, -16'sd255, -16'sd128, -16'sd1})
      begin n_fail++; $display("FAIL tanh_neg got v=%b %h exp v=1 %h", out_valid, out_data, {-16'sd256, -16'sd255, -16'sd128, -16'sd1}); end
    tick();
  endtask

  task automatic test_lrelu();
`ifdef ACT_SAT_COUNT_EN
    logic [15:0] before;
    before = sat_cnt;
`endif
    put({16'h8000, 16'd0, 16'd300, -16'sd1024}, 2'b00, 16'd26);
    tick();
    put({16'd1, 16'd0, 16'd7, 16'h8000}, 2'b00, 16'h8000);
    tick();
    put({-16'sd3, 16'd32767, -16'sd32767, -16'sd1}, 2'b00, 16'd128);
    n_checks++; if (out_valid !== 1'b1 || out_data !== {-16'sd3328, 16'd0, 16'd300, -16'sd104})
      begin n_fail++; $display("FAIL lrelu_slope26 got v=%b %h exp v=1 %h", out_valid, out_data, {-16'sd3328, 16'd0, 16'd300, -16'sd104}); end
    tick();
    in_valid = 1'b0;
    n_checks++; if (out_valid !== 1'b1 || out_data !== {16'd1, 16'd0, 16'd7, 16'h7FFF})
      begin n_fail++; $display("FAIL lrelu_sat got v=%b %h exp v=1 %h", out_valid, out_data, {16'd1, 16'd0, 16'd7, 16'h7FFF}); end
    tick();
    n_checks++; if (out_valid !== 1'b1 || out_data !== {-16'sd2, 16'd32767, -16'sd16384, -16'sd1})
      begin n_fail++; $display("FAIL lrelu_floor got v=%b %h exp v=1 %h", out_valid, out_data, {-16'sd2, 16'd32767, -16'sd16384, -16'sd1}); end
`ifdef ACT_SAT_COUNT_EN
    n_checks++; if (sat_cnt !== 16'(before + 16'd1)) begin n_fail++; $display("FAIL sat_cnt_inc got %0d exp %0d", sat_cnt, before + 16'd1); end
`endif
    tick();
`ifdef ACT_SAT_COUNT_EN
    n_checks++; if (sat_cnt !== 16'(before + 16'd1)) begin n_fail++; $display("FAIL sat_cnt_hold got %0d exp %0d", sat_cnt, before + 16'd1); end
    put({16'd1, 16'd0, 16'd7, 16'h8000}, 2'b00, 16'h8000);
    tick();
    in_valid = 1'b0;
    tick();
    sat_clr = 1'b1;
    tick();
    sat_clr = 1'b0;
    n_checks++; if (sat_cnt !== 16'd0) begin n_fail++; $display("FAIL sat_clr_priority got %0d exp 0", sat_cnt); end
    tick();
    n_checks++; if (sat_cnt !== 16'd0) begin n_fail++; $display("FAIL sat_clr_stay got %0d exp 0", sat_cnt); end
`endif
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      if (k >= 2) begin
        n_checks++; if (out_valid !== 1'b1 || out_data !== pat(k - 2))
          begin n_fail++; $display("FAIL b2b_beat%0d got v=%b %h exp v=1 %h", k - 2, out_valid, out_data, pat(k - 2)); end
      end
      if (k < 8) put(pat(k), 2'b11, 16'd0);
      else in_valid = 1'b0;
      tick();
    end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_drain got %b exp 0", out_valid); end
  endtask

  task automatic test_stall();
    int sent = 0, rcv = 0, cyc = 0;
    bit dropped_seen = 0, prev_stall = 0;
    logic [63:0] held = 64'd0;
    while (rcv < 8 && cyc < 60) begin
      out_ready = (cyc >= 5);
      if (sent < 8) put(pat(100 + sent), 2'b11, 16'd0);
      else in_valid = 1'b0;
      #1;
      if (!dropped_seen && sent < 8 && !in_ready) begin
        dropped_seen = 1;
        n_checks++; if (sent !== 2) begin n_fail++; $display("FAIL stall_ready_drop got %0d accepted exp 2", sent); end
      end
      if (out_valid && prev_stall) begin
        n_checks++; if (out_data !== held) begin n_fail++; $display("FAIL stall_hold got %h exp %h", out_data, held); end
      end
      if (out_valid && out_ready) begin
        n_checks++; if (out_data !== pat(100 + rcv))
          begin n_fail++; $display("FAIL stall_order_beat%0d got %h exp %h", rcv, out_data, pat(100 + rcv)); end
        rcv++;
      end
      prev_stall = out_valid && !out_ready;
      held = out_data;
      if (in_valid && in_ready) sent++;
      @(posedge clk);
      #1;
      cyc++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    n_checks++; if (rcv !== 8) begin n_fail++; $display("FAIL stall_count got %0d beats exp 8", rcv); end
    n_checks++; if (dropped_seen !== 1'b1) begin n_fail++; $display("FAIL stall_backpressure got %b exp 1", dropped_seen); end
    tick();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL stall_no_dup got %b exp 0", out_valid); end
  endtask

  task automatic test_mid_reset();
    out_ready = 1'b1;
    put(pat(200), 2'b11, 16'd0);
    tick();
    put(pat(201), 2'b11, 16'd0);
    tick();
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL mrst_in_ready got %b exp 0", in_ready); end
    tick();
    n_checks++; if (out_valid !== 1'b0 || out_data !== 64'd0)
      begin n_fail++; $display("FAIL mrst_clear got v=%b %h exp v=0 0", out_valid, out_data); end
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mrst_stale%0d got %b exp 0", k, out_valid); end
    end
    put(pat(202), 2'b11, 16'd0);
    tick();
    in_valid = 1'b0;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mrst_first_early got %b exp 0", out_valid); end
    tick();
    n_checks++; if (out_valid !== 1'b1 || out_data !== pat(202))
      begin n_fail++; $display("FAIL mrst_first_beat got v=%b %h exp v=1 %h", out_valid, out_data, pat(202)); end
    tick();
  endtask

  initial begin
    test_reset();
    test_sigmoid();
    test_tanh();
    test_lrelu();
    test_back_to_back();
    test_stall();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/activation_unit.md
ACTIVATION_UNIT -- requirements
Module: activation_unit

Interface
REQ-001 SHALL have parameter W, default 16, meaning the signed fixed-point data width per lane.
REQ-002 SHALL have parameter FRAC, default 8, meaning the number of fractional bits; legal when FRAC>=2 and W>=FRAC+3.
REQ-003 SHALL have parameter LANES, default 4, meaning the number of parallel channels sharing one handshake.
REQ-004 SHALL have one clock and a synchronous, active-low reset: clk input 1, rising-edge clock.
REQ-005 SHALL have port rst_n, input, width 1: synchronous active-low reset.
REQ-006 SHALL have port in_valid, input, width 1: input beat valid.
REQ-007 SHALL have port in_ready, output, width 1: input beat accepted when high with in_valid.
REQ-008 SHALL have port in_data, input, width LANES*W: packed signed lanes, lane 0 at LSBs.
REQ-009 SHALL have port in_mode, input, width 2: 00 LReLU, 01 sigmoid, 10 tanh, 11 bypass.
REQ-010 SHALL have port in_slope, input, width W: signed Q(FRAC) LReLU slope, shared by all lanes.
REQ-011 SHALL have port out_valid, output, width 1: output beat valid.
REQ-012 SHALL have port out_ready, input, width 1: downstream accepts.
REQ-013 SHALL have port out_data, output, width LANES*W: packed results, same lane order.

Function
REQ-014 SHALL sample in_data, in_mode and in_slope together on each accepted beat (in_valid && in_ready).
REQ-015 SHALL implement a 2-stage pipeline: stage 1 captures |x|, sign, segment class and the LReLU product; stage 2 combines, saturates and drives out_data/out_valid; latency 2 cycles with out_ready high.
REQ-016 SHALL advance the whole pipeline when advance = !out_valid || out_ready; in_ready = advance (combinational); a stalled pipeline holds out_data and out_valid stable.
REQ-017 SHALL preserve beat order, never drop or duplicate a beat, and sustain one beat per cycle when out_ready is held high.
REQ-018 LReLU: y = x when x>0, else (x*in_slope)>>>FRAC computed at 2W bits.
REQ-019 Sigmoid, with u=|x|: f=0.25u+0.5 for u<1.0; f=0.125u+0.625 for 1.0<=u<3.0; f=1.0 for u>=3.0; y=f for x>=0, else y=1.0-f.
REQ-020 Tanh, with u=|x|: f=u for u<0.5; f=0.5u+0.25 for 0.5<=u<1.5; f=1.0 for u>=1.5; y=f for x>=0, else y=-f.
REQ-021 Bypass: y=x.
REQ-022 All scaling SHALL use arithmetic shifts only, with floor rounding; no multiplier outside LReLU.
REQ-023 Every result SHALL saturate to [-2^(W-1), 2^(W-1)-1]; |x| of the most-negative input saturates to 2^(W-1)-1.
REQ-024 Segment boundaries SHALL be inclusive on the upper segment exactly as written in REQ-019 and REQ-020.

Reset
REQ-025 While rst_n is low at a clock edge: out_valid=0, out_data=0, all stage registers and valids=0, and in_ready=0 combinationally.
REQ-026 Reset mid-operation SHALL discard all in-flight beats; the first beat after reset SHALL appear after 2 cycles.

Configuration
REQ-027 With ACT_SAT_COUNT_EN defined: add ports sat_clr (input, width 1) and sat_cnt (output, width 16).
REQ-028 With ACT_SAT_COUNT_EN defined: sat_cnt increments once per output beat accepted downstream in which any lane saturated per REQ-023; it sticks at 0xFFFF, resets to 0, and sat_clr has priority over an increment.
REQ-029 Without ACT_SAT_COUNT_EN: the ports and counter are absent and the remaining behaviour is identical.

Structure
REQ-030 Shared package act_pkg SHALL hold the mode enum (ACT_LRELU, ACT_SIGMOID, ACT_TANH, ACT_BYPASS) and the breakpoint and offset constants expressed as functions of FRAC.
REQ-031 Sub-module act_lane SHALL contain one lane's two-stage datapath and saturation flag with a shared advance enable; the top SHALL instantiate LANES copies plus the handshake control.

Verification (W=16, FRAC=8, 1.0=256)
REQ-032 Sigmoid on lanes {0, 512, -512, 1024} -> {128, 224, 32, 256}, out_valid exactly 2 cycles after the beat is accepted.
REQ-033 Tanh on lanes {64, 256, -256, 512} -> {64, 192, -192, 256}.
REQ-034 LReLU with slope=26 on lanes {-1024, 300, 0, -32768} -> {-104, 300, 0, -3328}; with slope=-32768 and x=-32768 -> 32767, and sat_cnt increments when ACT_SAT_COUNT_EN is defined.
REQ-035 Send 8 continuous beats while holding out_ready=0 for 5 cycles -> in_ready drops after 2 accepted beats, out_data is held stable, and all 8 results emerge in order with none lost.
REQ-036 Assert rst_n=0 for 1 cycle with 2 beats in flight -> out_valid=0 and out_data=0 on the next edge, and no stale beat appears afterwards.
